cd_7seg_scan_ctrl: RTL
======================

Name: cd_7seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a common-anode, N-digit 7-segment display. It holds a frame of packed BCD digits and sequences one digit at a time through a BCD-to-7-segment decoder. For each digit it drives the matching anode, with a dead interval between digits to suppress ghosting. New frames are double-buffered so that a host update never tears a displayed frame.

Parameters:
N_DIGITS, 4, number of display digits (2..8)
DIGIT_CYC, 100000, clock cycles per digit slot, including dead time (>= DEAD_CYC+2)
DEAD_CYC, 1000, cycles at the start of each slot with all anodes off (>= 1)
CNT_W, 17, slot counter width (must hold DIGIT_CYC-1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  scan enable; 0 blanks the display
load  in  1  one-cycle strobe that offers a new frame on digits_in/dp_in
digits_in  in  4*N_DIGITS  packed BCD; digit 0 (rightmost) in bits [3:0]
dp_in  in  N_DIGITS  decimal-point request per digit
lz_blank  in  1  1 = blank leading zeros (digit N-1 downwards, never digit 0)
an  out  N_DIGITS  anode enables, active-low, one-hot-low when lit
seg  out  7  segments a..g (seg[0]=a), active-low
dp  out  1  decimal point, active-low
upd_ack  out  1  one-cycle pulse when a loaded frame becomes active
frame_done  out  1  one-cycle pulse when the digit index wraps N-1 -> 0

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, slot counter=0, index=0, pend=0, active/pending buffers=0.
  - an/seg/dp all 1 (everything off); upd_ack=0, frame_done=0.
- FSM states: IDLE, DEAD, ON.
  - IDLE: en=1 -> DEAD, index=0, counter=0.
  - DEAD: lasts DEAD_CYC cycles (counter 0..DEAD_CYC-1); an all 1, seg/dp all 1.
  - DEAD -> ON when counter=DEAD_CYC-1.
  - ON: counter DEAD_CYC..DIGIT_CYC-1. an[index]=0, others 1; seg = decode(active[index]); dp = ~dp_active[index].
  - ON at counter=DIGIT_CYC-1 -> DEAD; counter=0; index advances, wrapping N_DIGITS-1 -> 0.
  - en=0 in any state -> IDLE on the next edge; outputs go off that same edge.
- Outputs an/seg/dp are registered and change on the clock edge on which the state/counter enters the value described above; there is no extra pipeline.
- Digit slot period = DIGIT_CYC; frame period = N_DIGITS*DIGIT_CYC.
- frame_done is asserted the cycle after the ON->DEAD transition that wraps index to 0.
- Loading:
  - load=1 captures digits_in/dp_in into pending and sets pend=1. A later load before transfer overwrites pending (last wins).
  - Transfer pending->active happens on the wrap edge, or on the next edge when in IDLE. It clears pend and pulses upd_ack the following cycle.
  - load coincident with the wrap edge: digits_in is bypassed straight to active; pend stays 0; upd_ack still pulses.
- Leading-zero blanking (lz_blank=1):
  - Digit k is blanked (seg all 1, dp unaffected) when active digits N-1..k are all 0 and k>0.
  - The anode is still driven in that slot (constant brightness timing).
- BCD codes 10..15 are blanked (seg all 1).
- Reset mid-frame: immediate blank; pending data lost; no upd_ack.

Decomposition:
- Package cd_7seg_pkg: state enum (IDLE/DEAD/ON), SEG_OFF=7'h7F, segment patterns for 0..9 (active-low a..g).
- Sub-module cd_bcd7seg_dec: combinational 4-bit BCD -> 7-bit active-low segments plus a blank input. It is reused by the controller and is cross-checkable against the existing structural/behavioural decoders.

Test Plan (N_DIGITS=4, DIGIT_CYC=8, DEAD_CYC=2):
- Reset, en=1, then load digits_in=16'h1234, dp_in=0 in IDLE -> upd_ack one cycle later. Slot 0: an=1111 for 2 cycles, then an=1110, seg=pattern(4) for 6 cycles. Slots 1..3 follow the same timing with 3, 2, 1. frame_done at cycle 32 after enable.
- Mid-frame load 16'h5678 during slot 1 -> frame stays 1234 through slot 3. At the wrap, active=5678 and upd_ack pulses; slot 0 then shows 8.
- Two loads (16'h1111, then 16'h2222) in one frame -> only 2222 is displayed. Exactly one upd_ack.
- load 16'h9999 on the exact wrap edge -> slot 0 of the next frame shows 9. pend=0; one upd_ack.
- lz_blank=1 with 16'h0050 -> digits 3 and 2 seg=7F with their anodes still pulsed; digit 1 shows 5, digit 0 shows 0. With 16'h0000, only digit 0 shows 0.
- rst_n=0 during slot 2 ON -> an/seg/dp=all 1 asynchronously. After release with en=1, scanning restarts at index 0 with DEAD. Digit code 4'hA -> seg=7F.

Source files
------------

// File: rtl/cd_7seg_pkg.sv
// Shared types and segment encodings for the 7-segment scan controller.
// Segment vectors are active-low with bit 0 = segment a through bit 6 = segment g.
package cd_7seg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEAD = 2'd1,
    ON   = 2'd2
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  // Non-decimal codes 10..15 render as a dark digit.
  function automatic logic [6:0] seg_pattern(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_OFF;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/cd_bcd7seg_dec.sv
// BCD to active-low 7-segment decoder with a forced-blank input.
// Purely combinational, zero latency; no flow control.
module cd_bcd7seg_dec
  import cd_7seg_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    if (!blank) seg = seg_pattern(bcd);
  end

endmodule

// File: rtl/cd_7seg_scan_ctrl.sv
// Double-buffered, time-multiplexed scan controller for a common-anode N-digit display.
// Registered outputs change on the edge that enters each DEAD/ON phase; no backpressure, load is fire-and-forget.
module cd_7seg_scan_ctrl
  import cd_7seg_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int DIGIT_CYC = 100000,
  parameter int DEAD_CYC  = 1000,
  parameter int CNT_W     = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  lz_blank,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  upd_ack,
  output logic                  frame_done
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(DIGIT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

  scan_state_t                state;
  logic [CNT_W-1:0]           cnt;
  logic [IDX_W-1:0]           idx;

  logic                       pend;
  logic [N_DIGITS-1:0][3:0]   pend_dig;
  logic [N_DIGITS-1:0]        pend_dp;
  logic [N_DIGITS-1:0][3:0]   act_dig;
  logic [N_DIGITS-1:0]        act_dp;

  logic [N_DIGITS-1:0]        lz_blk;
  logic [N_DIGITS-1:0]        an_lit;
  logic [6:0]                 dec_seg;
  logic                       wrap;
  logic                       xfer;

  // A digit is a leading zero only if it and every digit above it are zero.
  always_comb begin : lz_scan
    logic nz_above;
    nz_above = 1'b0;
    lz_blk   = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      nz_above  = nz_above | (act_dig[k] != 4'd0);
      lz_blk[k] = lz_blank && (k != 0) && !nz_above;
    end
  end

  always_comb begin
    an_lit      = '1;
    an_lit[idx] = 1'b0;
  end

  cd_bcd7seg_dec u_dec (
    .bcd   (act_dig[idx]),
    .blank (lz_blk[idx]),
    .seg   (dec_seg)
  );

  assign wrap = en && (state == ON) && (cnt == SLOT_LAST) && (idx == IDX_LAST);
  assign xfer = (state == IDLE) || wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      an         <= '1;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      an         <= '1;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      if (!en) begin
        state <= IDLE;
        cnt   <= '0;
        idx   <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= DEAD;
            cnt   <= '0;
            idx   <= '0;
          end
          DEAD: begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == DEAD_LAST) begin
              state <= ON;
              an    <= an_lit;
              seg   <= dec_seg;
              dp    <= ~act_dp[idx];
            end
          end
          ON: begin
            if (cnt == SLOT_LAST) begin
              state <= DEAD;
              cnt   <= '0;
              idx   <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end else begin
              cnt <= cnt + CNT_W'(1);
              an  <= an_lit;
              seg <= dec_seg;
              dp  <= ~act_dp[idx];
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // A load that lands on a transfer edge goes straight to the active frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= 1'b0;
      pend_dig <= '0;
      pend_dp  <= '0;
      act_dig  <= '0;
      act_dp   <= '0;
      upd_ack  <= 1'b0;
    end else begin
      upd_ack <= 1'b0;
      if (xfer && (load || pend)) begin
        act_dig <= load ? digits_in : pend_dig;
        act_dp  <= load ? dp_in : pend_dp;
        pend    <= 1'b0;
        upd_ack <= 1'b1;
      end else if (load) begin
        pend_dig <= digits_in;
        pend_dp  <= dp_in;
        pend     <= 1'b1;
      end
    end
  end

endmodule
